// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback source select, sub-word load
// extraction, misaligned-load detection and a retired-instruction counter.
module writeback_stage #(
    parameter int DATA_W         = 32,
    parameter int REG_AW         = 5,
    parameter bit ZERO_REG_GUARD = 1'b1,
    parameter int OFF_W          = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        wb_sel,
    input  logic              RegWrite_in,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [OFF_W-1:0]  byte_offset,
    input  logic [DATA_W-1:0] mem_Read_data,
    input  logic [DATA_W-1:0] mem_ALU_result,
    input  logic [DATA_W-1:0] mem_link_pc,
    input  logic [DATA_W-1:0] mem_imm,
    input  logic [REG_AW-1:0] mem_Write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteReg,
    output logic              wb_valid,
    output logic              misalign,
    output logic [31:0]       retire_count
);

    logic              w_is_load;
    logic              w_misaligned;
    logic [OFF_W-1:0]  w_eff_off;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_next_data;
    logic              w_zero_dst;
    logic              w_next_regwrite;

    logic [DATA_W-1:0] r_wb_data;
    logic              r_regwrite;
    logic [REG_AW-1:0] r_write_reg;
    logic              r_wb_valid;
    logic              r_misalign;
    logic [31:0]       r_retire_count;

    assign w_is_load = (wb_sel == 2'b01);

    always_comb begin
        w_misaligned = 1'b0;
        if (in_valid && w_is_load) begin
            if (mem_size == 2'b01)
                w_misaligned = byte_offset[0];
            else if (mem_size[1])
                w_misaligned = (byte_offset != '0);
        end
    end

    // Misaligned accesses still return data, taken from the offset rounded
    // down to the access size, so the offset is aligned before the shift.
    always_comb begin
        w_eff_off = byte_offset;
        if (mem_size == 2'b01)
            w_eff_off = {byte_offset[OFF_W-1:1], 1'b0};
        else if (mem_size[1])
            w_eff_off = '0;
    end

    assign w_shifted = mem_Read_data >> {w_eff_off, 3'b000};

    always_comb begin
        w_load_data = mem_Read_data;
        case (mem_size)
            2'b00:   w_load_data = {{(DATA_W-8){~mem_unsigned & w_shifted[7]}},
                                    w_shifted[7:0]};
            2'b01:   w_load_data = {{(DATA_W-16){~mem_unsigned & w_shifted[15]}},
                                    w_shifted[15:0]};
            default: w_load_data = mem_Read_data;
        endcase
    end

    always_comb begin
        w_next_data = mem_ALU_result;
        case (wb_sel)
            2'b00:   w_next_data = mem_ALU_result;
            2'b01:   w_next_data = w_load_data;
            2'b10:   w_next_data = mem_link_pc;
            default: w_next_data = mem_imm;
        endcase
    end

    assign w_zero_dst      = ZERO_REG_GUARD && (mem_Write_reg == '0);
    assign w_next_regwrite = in_valid & RegWrite_in & ~w_misaligned & ~w_zero_dst;

    // Flush beats stall; a flushed slot neither retires nor writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_data      <= '0;
            r_regwrite     <= 1'b0;
            r_write_reg    <= '0;
            r_wb_valid     <= 1'b0;
            r_misalign     <= 1'b0;
            r_retire_count <= '0;
        end else if (flush) begin
            r_regwrite <= 1'b0;
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_wb_data   <= w_next_data;
            r_regwrite  <= w_next_regwrite;
            r_write_reg <= mem_Write_reg;
            r_wb_valid  <= in_valid;
            r_misalign  <= w_misaligned;
            if (in_valid)
                r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign wb_data      = r_wb_data;
    assign RegWrite     = r_regwrite;
    assign WriteReg     = r_write_reg;
    assign wb_valid     = r_wb_valid;
    assign misalign     = r_misalign;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: inputs change mid-cycle, outputs are
// checked 1 time unit after the rising edge that captured them.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid, RegWrite_in, mem_unsigned;
    logic [1:0]  wb_sel, mem_size;
    logic [1:0]  byte_offset;
    logic [31:0] mem_Read_data, mem_ALU_result, mem_link_pc, mem_imm;
    logic [4:0]  mem_Write_reg;
    logic [31:0] wb_data;
    logic        RegWrite, wb_valid, misalign;
    logic [4:0]  WriteReg;
    logic [31:0] retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .wb_sel(wb_sel), .RegWrite_in(RegWrite_in), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .byte_offset(byte_offset),
        .mem_Read_data(mem_Read_data), .mem_ALU_result(mem_ALU_result),
        .mem_link_pc(mem_link_pc), .mem_imm(mem_imm), .mem_Write_reg(mem_Write_reg),
        .wb_data(wb_data), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .wb_valid(wb_valid), .misalign(misalign), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic rw,
                         input logic [1:0] sz, input logic uns, input logic [1:0] off,
                         input logic [4:0] rd);
        in_valid = v; wb_sel = sel; RegWrite_in = rw; mem_size = sz;
        mem_unsigned = uns; byte_offset = off; mem_Write_reg = rd;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_Read_data = 32'h80FF7F01; mem_ALU_result = 32'hDEADBEEF;
        mem_link_pc = 32'h00400008; mem_imm = 32'hABCD0000;
        drive(1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 2'd0, 5'd5);
        step();
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_writereg", {27'd0, WriteReg}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_retire", retire_count, 32'd0);
        rst = 1'b0;

        // Valid ALU write to r5
        step();
        check("alu_data", wb_data, 32'hDEADBEEF);
        check("alu_regwrite", {31'd0, RegWrite}, 32'd1);
        check("alu_writereg", {27'd0, WriteReg}, 32'd5);
        check("alu_valid", {31'd0, wb_valid}, 32'd1);
        check("alu_retire", retire_count, 32'd1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("arst_wb_data", wb_data, 32'h0);
        check("arst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("arst_writereg", {27'd0, WriteReg}, 32'd0);
        check("arst_valid", {31'd0, wb_valid}, 32'd0);
        check("arst_retire", retire_count, 32'd0);
        #1 rst = 1'b0;

        // Sub-word loads from 0x80FF7F01
        drive(1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 2'd3, 5'd4);
        step();
        check("lb_s_data", wb_data, 32'hFFFFFF80);
        check("lb_s_misalign", {31'd0, misalign}, 32'd0);
        check("lb_s_regwrite", {31'd0, RegWrite}, 32'd1);
        drive(1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 2'd3, 5'd4);
        step();
        check("lb_u_data", wb_data, 32'h00000080);
        drive(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 2'd2, 5'd4);
        step();
        check("lh_s_data", wb_data, 32'hFFFF80FF);
        drive(1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 2'd0, 5'd4);
        step();
        check("lh_u_data", wb_data, 32'h00007F01);
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 2'd0, 5'd4);
        step();
        check("lw_data", wb_data, 32'h80FF7F01);
        check("lw_retire", retire_count, 32'd5);

        // Misaligned half and full loads
        drive(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 2'd1, 5'd7);
        step();
        check("mis_h_misalign", {31'd0, misalign}, 32'd1);
        check("mis_h_regwrite", {31'd0, RegWrite}, 32'd0);
        check("mis_h_valid", {31'd0, wb_valid}, 32'd1);
        check("mis_h_data", wb_data, 32'h00007F01);
        check("mis_h_retire", retire_count, 32'd6);
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 2'd2, 5'd7);
        step();
        check("mis_w_misalign", {31'd0, misalign}, 32'd1);
        check("mis_w_data", wb_data, 32'h80FF7F01);
        check("mis_w_retire", retire_count, 32'd7);

        // Stall holds, flush wins over stall
        mem_ALU_result = 32'h00001234;
        drive(1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 2'd0, 5'd3);
        step();
        check("pre_stall_data", wb_data, 32'h00001234);
        check("pre_stall_retire", retire_count, 32'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ALU_result = 32'h5555_0000 + i;
            mem_Write_reg  = 5'd9 + 5'(i);
            step();
            check("stall_data", wb_data, 32'h00001234);
            check("stall_writereg", {27'd0, WriteReg}, 32'd3);
            check("stall_regwrite", {31'd0, RegWrite}, 32'd1);
            check("stall_retire", retire_count, 32'd8);
        end
        flush = 1'b1;
        step();
        check("flush_regwrite", {31'd0, RegWrite}, 32'd0);
        check("flush_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_retire", retire_count, 32'd8);
        stall = 1'b0; flush = 1'b0;

        // Link PC, zero-register guard, immediate, bubble
        drive(1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'd0, 5'd31);
        step();
        check("link_data", wb_data, 32'h00400008);
        check("link_regwrite", {31'd0, RegWrite}, 32'd1);
        check("link_writereg", {27'd0, WriteReg}, 32'd31);
        drive(1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'd0, 5'd0);
        step();
        check("x0_regwrite", {31'd0, RegWrite}, 32'd0);
        check("x0_valid", {31'd0, wb_valid}, 32'd1);
        check("x0_retire", retire_count, 32'd10);
        drive(1'b1, 2'b11, 1'b1, 2'b10, 1'b0, 2'd0, 5'd2);
        step();
        check("imm_data", wb_data, 32'hABCD0000);
        drive(1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 2'd0, 5'd2);
        step();
        check("bubble_regwrite", {31'd0, RegWrite}, 32'd0);
        check("bubble_valid", {31'd0, wb_valid}, 32'd0);
        check("bubble_retire", retire_count, 32'd11);

        // Counter wrap
        force dut.r_retire_count = 32'hFFFFFFFF;
        #1 release dut.r_retire_count;
        drive(1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 2'd0, 5'd1);
        step();
        check("wrap_retire", retire_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
